// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite timer peripheral: CTRL/LOAD/COUNT/STATUS registers, a prescaled
// 32-bit down-counter with optional auto-reload, and a level interrupt.
module axi_lite_timer_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PRESCALE           = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            IRQ
);

  typedef enum logic [1:0] {REG_CTRL, REG_LOAD, REG_COUNT, REG_STATUS} reg_addr_e;

  logic [31:0] ctrl_q, ctrl_d, load_q, load_d, count_q, count_d;
  logic        expired_q, expired_d;
  logic [15:0] prescale_q, prescale_d;
  logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [1:0]  awaddr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs, w_hs, ar_hs, commit, tick;
  reg_addr_e   wr_addr;
  logic [31:0] wr_data, ctrl_wr;
  logic [3:0]  wr_strb;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  // Readies are gated by ARESET so every output is low for the whole reset window.
  assign S_AXI_AWREADY = !ARESET && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !ARESET && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign IRQ           = expired_q & ctrl_q[2];

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_held_q ? reg_addr_e'(awaddr_q) : reg_addr_e'(S_AXI_AWADDR[3:2]);
  assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign ctrl_wr = apply_strb(ctrl_q, wr_data, wr_strb);
  assign tick    = ctrl_q[0] && (prescale_q == 16'(PRESCALE - 1));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;

    // The clear is applied before the tick so a same-edge expiry wins.
    if (commit && wr_addr == REG_STATUS && wr_strb[0] && wr_data[0]) expired_d = 1'b0;

    if (ctrl_q[0]) prescale_d = tick ? 16'd0 : prescale_q + 16'd1;
    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[1]) count_d   = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    // CTRL writes come last: they override any tick on the same edge.
    if (commit) begin
      case (wr_addr)
        REG_CTRL: begin
          ctrl_d = ctrl_wr;
          if (ctrl_wr[0] && !ctrl_q[0]) begin
            count_d    = load_q;
            prescale_d = 16'd0;
          end else if (!ctrl_wr[0]) begin
            count_d    = count_q;
            prescale_d = 16'd0;
          end
        end
        REG_LOAD: load_d = apply_strb(load_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      prescale_q <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;

      if (aw_hs) awaddr_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      aw_held_q <= !commit && (aw_held_q || aw_hs);
      w_held_q  <= !commit && (w_held_q || w_hs);

      if (commit)                         bvalid_q <= 1'b1;
      else if (bvalid_q && S_AXI_BREADY)  bvalid_q <= 1'b0;

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        case (reg_addr_e'(S_AXI_ARADDR[3:2]))
          REG_CTRL:  rdata_q <= ctrl_q;
          REG_LOAD:  rdata_q <= load_q;
          REG_COUNT: rdata_q <= count_q;
          default:   rdata_q <= {31'd0, expired_q};
        endcase
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_timer_slave.sv
// Directed bench for axi_lite_timer_slave (PRESCALE=1): register access,
// one-shot and auto-reload timing, handshake ordering, WSTRB and reset.
module tb_axi_lite_timer_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  axi_lite_timer_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .PRESCALE(1)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   n;
    logic got_aw, got_w;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      got_aw = awvalid && awready;
      got_w  = wvalid && wready;
      step(1);
      if (got_aw) awvalid = 1'b0;
      if (got_w)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    step(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int   n;
    logic got;
    araddr = addr; arvalid = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 20) begin
      got = arready;
      step(1);
      n++;
    end
    arvalid = 1'b0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rresp", 32'(rresp), 32'd0);
    data = rdata;
    rready = 1'b1;
    step(1);
    rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, exp);
  endtask

  // Presents W at cycle w_at and AW at cycle aw_at, then stalls BREADY for 4 cycles.
  task automatic ordered_write(input int w_at, input int aw_at, input logic [31:0] data);
    int   n;
    logic got_aw, got_w;
    awaddr = 4'h4; wdata = data; wstrb = 4'hF; bready = 1'b0; n = 0;
    while (!bvalid && n < 20) begin
      if (n == w_at)  wvalid  = 1'b1;
      if (n == aw_at) awvalid = 1'b1;
      got_aw = awvalid && awready;
      got_w  = wvalid && wready;
      step(1);
      if (got_aw) awvalid = 1'b0;
      if (got_w)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("ord_bvalid", 32'(bvalid), 32'd1);
    repeat (4) begin
      check("ord_hold_bvalid", 32'(bvalid), 32'd1);
      check("ord_awready_low", 32'(awready), 32'd0);
      check("ord_wready_low", 32'(wready), 32'd0);
      step(1);
    end
    bready = 1'b1;
    step(1);
    bready = 1'b0;
    check("ord_bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"}, 32'(wready), 32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    step(1);
    check_outputs_zero("reset");
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) read_check("reset_reg", 4'(4 * i), 32'd0);

    // CTRL=1 with LOAD=0 expires on the very next tick and self-clears EN.
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    read_check("t1_ctrl", 4'h0, 32'h0);
    read_check("t1_load", 4'h4, 32'h2);
    read_check("t1_count", 4'h8, 32'h0);
    read_check("t1_status", 4'hC, 32'h1);
    check("t1_irq", 32'(irq), 32'd0);
    axi_write(4'hC, 32'h1, 4'hF);
    read_check("t1_status_clr", 4'hC, 32'h0);

    // One-shot: commit edge C, COUNT 5..0 on C..C+5, expiry at C+6.
    axi_write(4'h4, 32'd5, 4'hF);
    axi_write(4'h0, 32'h5, 4'hF);
    read_check("t2_count_c1", 4'h8, 32'd4);
    for (int k = 3; k <= 7; k++) begin
      check($sformatf("t2_irq_c%0d", k), 32'(irq), (k >= 6) ? 32'd1 : 32'd0);
      step(1);
    end
    read_check("t2_ctrl", 4'h0, 32'h4);
    read_check("t2_count", 4'h8, 32'd0);
    read_check("t2_status", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'hF);
    check("t2_irq_clr", 32'(irq), 32'd0);
    read_check("t2_status_clr", 4'hC, 32'h0);

    // Auto-reload LOAD=3: expiries at C+4, C+8, C+12, C+16.
    axi_write(4'h4, 32'd3, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    read_check("t3_status_c1", 4'hC, 32'h0);
    read_check("t3_status_c3", 4'hC, 32'h0);
    read_check("t3_status_c5", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'hF);
    read_check("t3_set_wins", 4'hC, 32'h1);
    step(1);
    axi_write(4'hC, 32'h1, 4'hF);
    read_check("t3_w1c", 4'hC, 32'h0);
    read_check("t3_count_c16", 4'h8, 32'd3);
    axi_write(4'h0, 32'h0, 4'hF);
    read_check("t3_count_frozen", 4'h8, 32'd1);
    read_check("t3_status_c16", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'hF);

    ordered_write(0, 3, 32'hA1A1_0001);
    read_check("t4_w_first", 4'h4, 32'hA1A1_0001);
    ordered_write(3, 0, 32'hB2B2_0002);
    read_check("t4_aw_first", 4'h4, 32'hB2B2_0002);
    ordered_write(0, 0, 32'hC3C3_0003);
    read_check("t4_together", 4'h4, 32'hC3C3_0003);

    axi_write(4'h4, 32'h1122_3344, 4'hF);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0010);
    read_check("t5_wstrb", 4'h4, 32'h1122_CC44);

    // Reset while BVALID=1 and COUNT has just loaded 7.
    axi_write(4'h4, 32'd7, 4'hF);
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t6_pre_bvalid", 32'(bvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    step(1);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) read_check("t6_reg", 4'(4 * i), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
